// File: rtl/step_ring_fsm_if.sv
// ============================================================================
// Module   : step_ring_fsm_if
// Brief    : Board-side signal bundle for step_ring_fsm (button, guards, state).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface step_ring_fsm_if #(
    parameter int NSTATES = 4
);
    logic               BTN;
    logic               DIR;
    logic [NSTATES-1:0] GUARD;
    logic [NSTATES-1:0] STATE;
    logic               STEP;
    logic               BLOCKED;
    logic               ERR;

    modport master (
        output BTN, DIR, GUARD,
        input  STATE, STEP, BLOCKED, ERR
    );

    modport slave (
        input  BTN, DIR, GUARD,
        output STATE, STEP, BLOCKED, ERR
    );
endinterface

`default_nettype wire

// File: rtl/step_ring_fsm.sv
// ============================================================================
// Module   : step_ring_fsm
// Brief    : One-hot N-state ring stepped by a debounced push-button, with
//            direction, per-state entry guards and step/blocked pulses.
//            Optional illegal-state recovery: STEP_RING_ONEHOT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_ring_fsm #(
    parameter int NSTATES    = 4,
    parameter int PRESCALE_W = 16,
    parameter int DEBOUNCE   = 2
) (
    input  wire logic         CLKIN,
    input  wire logic         RESET,
    step_ring_fsm_if.slave    bus
);

    localparam int IDX_W = (NSTATES > 1) ? $clog2(NSTATES) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NSTATES - 1);

    logic [PRESCALE_W-1:0] r_presc;
    logic                  w_tick;
    logic [DEBOUNCE-1:0]   r_sample;
    logic [DEBOUNCE-1:0]   w_sample_next;
    logic                  r_db;
    logic                  r_db_prev;
    logic                  r_press;

    logic [NSTATES-1:0]    r_state;
    logic [NSTATES-1:0]    w_state_next;
    logic                  r_step;
    logic                  w_step_next;
    logic                  r_blocked;
    logic                  w_blocked_next;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_tgt;
    logic                  w_any;

    assign w_tick        = &r_presc;
    assign w_sample_next = (r_sample << 1) | DEBOUNCE'(bus.BTN);

    // Button front end: tick-sampled shift register, run-length debounce, edge detect
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            r_presc   <= '0;
            r_sample  <= '0;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_presc   <= r_presc + 1'b1;
            r_db_prev <= r_db;
            r_press   <= r_db & ~r_db_prev;
            if (w_tick) begin
                r_sample <= w_sample_next;
                if (&w_sample_next) begin
                    r_db <= 1'b1;
                end else if (~|w_sample_next) begin
                    r_db <= 1'b0;
                end
            end
        end
    end

    // Lowest set bit defines the current index, so an illegal vector still has a successor
    always_comb begin
        w_idx = '0;
        for (int k = NSTATES - 1; k >= 0; k--) begin
            if (r_state[k]) begin
                w_idx = IDX_W'(k);
            end
        end
        w_any = |r_state;
        if (bus.DIR) begin
            w_tgt = (w_idx == '0) ? c_last_idx : (w_idx - IDX_W'(1));
        end else begin
            w_tgt = (w_idx == c_last_idx) ? '0 : (w_idx + IDX_W'(1));
        end
    end

`ifdef STEP_RING_ONEHOT_CHECK_EN
    logic r_err;
    logic w_err_next;
    logic w_onehot;

    assign w_onehot = w_any && ((r_state & (r_state - 1'b1)) == '0);
`endif

    always_comb begin
        w_state_next   = r_state;
        w_step_next    = 1'b0;
        w_blocked_next = 1'b0;
`ifdef STEP_RING_ONEHOT_CHECK_EN
        w_err_next     = 1'b0;
`endif
        if (r_press && w_any) begin
            if (bus.GUARD[w_tgt]) begin
                w_state_next        = '0;
                w_state_next[w_tgt] = 1'b1;
                w_step_next         = 1'b1;
            end else begin
                w_blocked_next = 1'b1;
            end
        end
`ifdef STEP_RING_ONEHOT_CHECK_EN
        // Recovery overrides any press seen in the same cycle
        if (!w_onehot) begin
            w_state_next   = NSTATES'(1);
            w_step_next    = 1'b0;
            w_blocked_next = 1'b0;
            w_err_next     = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            r_state   <= NSTATES'(1);
            r_step    <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_step    <= w_step_next;
            r_blocked <= w_blocked_next;
        end
    end

`ifdef STEP_RING_ONEHOT_CHECK_EN
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign bus.ERR = r_err;
`else
    assign bus.ERR = 1'b0;
`endif

    assign bus.STATE   = r_state;
    assign bus.STEP    = r_step;
    assign bus.BLOCKED = r_blocked;

endmodule

`default_nettype wire

// File: tb/tb_step_ring_fsm.sv
// ============================================================================
// Module   : tb_step_ring_fsm
// Brief    : Directed + randomised bench for step_ring_fsm against an
//            event-level reference model (honours STEP_RING_ONEHOT_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_ring_fsm;

    localparam int NSTATES    = 4;
    localparam int PRESCALE_W = 2;
    localparam int DEBOUNCE   = 2;
    localparam int TICK       = 1 << PRESCALE_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    step_ring_fsm_if #(.NSTATES(NSTATES)) bus ();

    step_ring_fsm #(
        .NSTATES    (NSTATES),
        .PRESCALE_W (PRESCALE_W),
        .DEBOUNCE   (DEBOUNCE)
    ) dut (
        .CLKIN (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int steps_seen  = 0;
    int blocks_seen = 0;

    // Reference model: edge counter, run of equal samples, scheduled press edge
    int m_n;
    int m_run_val;
    int m_run_len;
    int m_db;
    int m_press_at;
    int m_idx;
    int m_step;
    int m_blk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_n        = 0;
        m_run_val  = 0;
        m_run_len  = DEBOUNCE;
        m_db       = 0;
        m_press_at = -1;
        m_idx      = 0;
        m_step     = 0;
        m_blk      = 0;
    endtask

    task automatic model_edge();
        int tgt;
        int s;
        if (rst) begin
            model_reset();
            return;
        end
        m_n++;
        m_step = 0;
        m_blk  = 0;
        if (m_press_at == m_n) begin
            tgt = bus.DIR ? (m_idx + NSTATES - 1) % NSTATES : (m_idx + 1) % NSTATES;
            if (bus.GUARD[tgt]) begin
                m_idx  = tgt;
                m_step = 1;
            end else begin
                m_blk = 1;
            end
        end
        if (m_n % TICK == 0) begin
            s = int'(bus.BTN);
            if (s == m_run_val) begin
                m_run_len++;
            end else begin
                m_run_val = s;
                m_run_len = 1;
            end
            if (m_run_len >= DEBOUNCE && m_run_val != m_db) begin
                m_db = m_run_val;
                if (m_db == 1) m_press_at = m_n + 2;
            end
        end
    endtask

    task automatic compare_all();
        logic [NSTATES-1:0] exp_state;
        exp_state = NSTATES'(1) << m_idx;
        check("state", 32'(bus.STATE), 32'(exp_state));
        check("step", 32'(bus.STEP), m_step);
        check("blocked", 32'(bus.BLOCKED), m_blk);
        check("err", 32'(bus.ERR), 0);
        check("db", 32'(dut.r_db), m_db);
        if (bus.STEP === 1'b1) steps_seen++;
        if (bus.BLOCKED === 1'b1) blocks_seen++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare_all();
        end
    endtask

    // Called at a negedge; asserts reset between edges and checks the immediate effect
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_state", 32'(bus.STATE), 32'(NSTATES'(1)));
        check("rst_step", 32'(bus.STEP), 0);
        check("rst_blocked", 32'(bus.BLOCKED), 0);
        check("rst_err", 32'(bus.ERR), 0);
        bus.BTN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input int hi, input int lo);
        bus.BTN = 1'b1;
        run(hi);
        bus.BTN = 1'b0;
        run(lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int b0;
        logic [NSTATES-1:0] exp_v;
        logic [NSTATES-1:0] bad_state;

        bus.BTN   = 1'b0;
        bus.DIR   = 1'b0;
        bus.GUARD = '1;
        model_reset();

        do_reset();
        run(100);

        // Forward ring
        for (int k = 0; k < NSTATES; k++) begin
            s0 = steps_seen;
            press(12, 12);
            exp_v = NSTATES'(1) << ((k + 1) % NSTATES);
            check("fwd_state", 32'(bus.STATE), 32'(exp_v));
            check("fwd_steps", steps_seen - s0, 1);
        end

        // Reverse
        bus.DIR = 1'b1;
        press(12, 12);
        exp_v = NSTATES'(1) << (NSTATES - 1);
        check("rev_state1", 32'(bus.STATE), 32'(exp_v));
        press(12, 12);
        exp_v = NSTATES'(1) << (NSTATES - 2);
        check("rev_state2", 32'(bus.STATE), 32'(exp_v));
        bus.DIR = 1'b0;

        // Reset in the middle of a press
        bus.BTN = 1'b1;
        run(9);
        do_reset();
        run(20);

        // Guard block, then unblock
        bus.GUARD = ~(NSTATES'(1) << 1);
        s0 = steps_seen;
        b0 = blocks_seen;
        press(12, 12);
        check("grd_state", 32'(bus.STATE), 1);
        check("grd_steps", steps_seen - s0, 0);
        check("grd_blocks", blocks_seen - b0, 1);
        bus.GUARD = '1;
        press(12, 12);
        check("grd_open", 32'(bus.STATE), 2);

        // Long hold: one step only
        s0 = steps_seen;
        press(40, 12);
        check("hold_steps", steps_seen - s0, 1);
        check("hold_state", 32'(bus.STATE), 4);

        // Bounce: single high sample, then alternating samples
        s0 = steps_seen;
        b0 = blocks_seen;
        press(TICK, 3 * TICK);
        check("bnc_db", 32'(dut.r_db), 0);
        for (int i = 0; i < 10; i++) begin
            bus.BTN = (i % 2 == 0);
            run(TICK);
        end
        bus.BTN = 1'b0;
        run(12);
        check("bnc_steps", steps_seen - s0, 0);
        check("bnc_blocks", blocks_seen - b0, 0);
        check("bnc_state", 32'(bus.STATE), 4);

        // Randomised button, direction and guard activity
        repeat (200) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) bus.GUARD = NSTATES'($urandom);
            bus.DIR = 1'($urandom_range(0, 1));
            bus.BTN = 1'($urandom_range(0, 1));
            run($urandom_range(1, 10));
        end
        bus.BTN = 1'b0;
        bus.GUARD = '1;
        run(20);

`ifdef STEP_RING_ONEHOT_CHECK_EN
        do_reset();
        run(10);
        bad_state = NSTATES'(6);
        force dut.r_state = bad_state;
        #1;
        release dut.r_state;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("chk_state", 32'(bus.STATE), 1);
        check("chk_err", 32'(bus.ERR), 1);
        check("chk_step", 32'(bus.STEP), 0);
        run(5);
`else
        bad_state = '0;
        check("err_tied", 32'(bus.ERR), 32'(bad_state));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
